// File: rtl/mux_scan_ctrl.sv
// Select sequencer for a 4:1 bit mux: scans enabled channels, dwells, samples y_in, publishes a snapshot.
// Optional continuous re-scan on DONE is enabled by defining MUX_SCAN_CONT_EN (adds input cont).
module mux_scan_ctrl #(
    parameter int unsigned DWELL = 2,
    parameter int unsigned CNT_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  mask,
    input  logic        y_in,
`ifdef MUX_SCAN_CONT_EN
    input  logic        cont,
`endif
    output logic [1:0]  sel,
    output logic        busy,
    output logic        done,
    output logic [3:0]  snap,
    output logic        valid
);

    localparam int unsigned CH_N  = 4;
    localparam int unsigned SEL_W = 2;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [SEL_W-1:0]   sel_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [CH_N-1:0]    shadow, shadow_d;
    logic [CH_N-1:0]    mask_q, mask_d;
    logic [CH_N-1:0]    snap_d;
    logic               busy_d, done_d, valid_d;

    logic [SEL_W-1:0]   first_sel;
    logic [SEL_W-1:0]   next_sel;
    logic               has_next;

    // Lowest enabled channel of the incoming mask, and next enabled channel above sel in the latched mask.
    always_comb begin
        first_sel = '0;
        next_sel  = sel;
        has_next  = 1'b0;
        for (int i = int'(CH_N) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first_sel = SEL_W'(i);
            end
            if (mask_q[i] && (i > int'(sel))) begin
                has_next = 1'b1;
                next_sel = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state;
        sel_d    = sel;
        cnt_d    = cnt;
        shadow_d = shadow;
        mask_d   = mask_q;
        snap_d   = snap;
        busy_d   = busy;
        done_d   = 1'b0;
        valid_d  = valid;

        case (state)
            IDLE: begin
                if (start) begin
                    shadow_d = '0;
                    if (mask != '0) begin
                        mask_d  = mask;
                        sel_d   = first_sel;
                        cnt_d   = '0;
                        valid_d = 1'b0;
                        busy_d  = 1'b1;
                        state_d = SCAN;
                    end else begin
                        snap_d  = '0;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end
                end
            end

            SCAN: begin
                cnt_d = cnt + CNT_W'(1);
                if (cnt == DWELL_LAST) begin
                    shadow_d[sel] = y_in;
                    if (has_next) begin
                        sel_d = next_sel;
                        cnt_d = '0;
                    end else begin
                        // Snapshot includes the bit sampled on this same edge.
                        snap_d  = shadow_d;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
`ifdef MUX_SCAN_CONT_EN
                if (cont) begin
                    shadow_d = '0;
                    if (mask != '0) begin
                        mask_d  = mask;
                        sel_d   = first_sel;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = SCAN;
                    end else begin
                        snap_d  = '0;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end
                end
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel    <= '0;
            cnt    <= '0;
            shadow <= '0;
            mask_q <= '0;
            snap   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            valid  <= 1'b0;
        end else begin
            state  <= state_d;
            sel    <= sel_d;
            cnt    <= cnt_d;
            shadow <= shadow_d;
            mask_q <= mask_d;
            snap   <= snap_d;
            busy   <= busy_d;
            done   <= done_d;
            valid  <= valid_d;
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed table-driven bench for mux_scan_ctrl (DWELL=2) with a behavioural 4:1 mux on y_in.
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] mask;
    logic [3:0] a;
    logic       y_in;
    logic [1:0] sel;
    logic       busy;
    logic       done;
    logic [3:0] snap;
    logic       valid;
`ifdef MUX_SCAN_CONT_EN
    logic       cont;
    initial cont = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    logic [3:0] prev_snap;

    typedef struct {
        logic [3:0]  a;
        logic [3:0]  mask;
        logic [3:0]  mask_chg;
        int          repulse;
        int          exp_done;
        logic [3:0]  exp_snap;
        logic [15:0] exp_sels;
        int          exp_nsel;
    } vec_t;

    vec_t vecs[7];

    assign y_in = a[sel];

    mux_scan_ctrl #(.DWELL(2), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mask  (mask),
        .y_in  (y_in),
`ifdef MUX_SCAN_CONT_EN
        .cont  (cont),
`endif
        .sel   (sel),
        .busy  (busy),
        .done  (done),
        .snap  (snap),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One start pulse on edge 0, then sample cycles 1..20 on the falling edge.
    task automatic run_vec(input int idx, input vec_t v);
        int          done_cyc;
        int          done_cnt;
        int          nsel;
        logic [15:0] sels;
        bit          busy_seen;
        logic [3:0]  snap_done;
        logic [3:0]  snap_c1;
        logic        valid_c1;
        done_cyc  = -1;
        done_cnt  = 0;
        nsel      = 0;
        sels      = '0;
        busy_seen = 1'b0;
        snap_done = 4'hx;
        snap_c1   = 4'hx;
        valid_c1  = 1'bx;
        @(negedge clk);
        a     = v.a;
        mask  = v.mask;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start    = 1'b0;
                valid_c1 = valid;
                snap_c1  = snap;
            end
            if (busy) begin
                busy_seen = 1'b1;
                if (nsel < 8) begin
                    sels = {sels[13:0], sel};
                    nsel++;
                end
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc  = c;
                    snap_done = snap;
                end
            end
            if (c == 2) mask = v.mask_chg;
            if (v.repulse > 0 && c == v.repulse) start = 1'b1;
            if (v.repulse > 0 && c == v.repulse + 1) start = 1'b0;
        end
        check($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done);
        check($sformatf("v%0d_done_count", idx), done_cnt, 1);
        check($sformatf("v%0d_snap", idx), 32'(snap_done), 32'(v.exp_snap));
        check($sformatf("v%0d_sel_seq", idx), 32'(sels), 32'(v.exp_sels));
        check($sformatf("v%0d_sel_count", idx), nsel, v.exp_nsel);
        check($sformatf("v%0d_busy_seen", idx), 32'(busy_seen), 32'(v.exp_nsel > 0));
        check($sformatf("v%0d_valid_c1", idx), 32'(valid_c1), 32'(v.mask == 4'b0000));
        check($sformatf("v%0d_snap_c1", idx), 32'(snap_c1),
              32'((v.mask == 4'b0000) ? v.exp_snap : prev_snap));
        check($sformatf("v%0d_valid_end", idx), 32'(valid), 32'd1);
        check($sformatf("v%0d_busy_end", idx), 32'(busy), 32'd0);
        prev_snap = v.exp_snap;
    endtask

    initial begin
        int rst_done_cnt;
        //          a        mask     mask_chg repulse done snap     sels     nsel
        vecs[0] = '{4'b1010, 4'b1111, 4'b1111, 0, 9, 4'b1010, 16'h05AF, 8};
        vecs[1] = '{4'b1111, 4'b0101, 4'b0101, 0, 5, 4'b0101, 16'h000A, 4};
        vecs[2] = '{4'b1111, 4'b0000, 4'b0000, 0, 1, 4'b0000, 16'h0000, 0};
        vecs[3] = '{4'b1010, 4'b1111, 4'b1111, 3, 9, 4'b1010, 16'h05AF, 8};
        vecs[4] = '{4'b1001, 4'b1000, 4'b1000, 0, 3, 4'b1000, 16'h000F, 2};
        vecs[5] = '{4'b0111, 4'b0110, 4'b0110, 0, 5, 4'b0110, 16'h005A, 4};
        vecs[6] = '{4'b1111, 4'b0011, 4'b1100, 0, 5, 4'b0011, 16'h0005, 4};

        rst_n     = 1'b0;
        start     = 1'b0;
        mask      = 4'b0000;
        a         = 4'b0000;
        prev_snap = 4'b0000;
        repeat (2) @(negedge clk);
        check("reset_sel", 32'(sel), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_snap", 32'(snap), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // Abort a scan with reset at cycle 4, release at cycle 6.
        rst_done_cnt = 0;
        @(negedge clk);
        a     = 4'b1010;
        mask  = 4'b1111;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c >= 4 && done) rst_done_cnt++;
            if (c == 4) begin
                rst_n = 1'b0;
                #1;
                check("abort_sel", 32'(sel), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_valid", 32'(valid), 32'd0);
                check("abort_snap", 32'(snap), 32'd0);
            end
            if (c == 6) rst_n = 1'b1;
        end
        check("abort_no_done", rst_done_cnt, 0);
        check("abort_idle_busy", 32'(busy), 32'd0);
        prev_snap = 4'b0000;
        run_vec(100, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
